mem_bus_arbiter: RTL and testbench

- Shares the single ALU/memory bus (enable, rd_wr, addr, wr_data, rd_data, res_out) among NUM_REQ requesters, e.g. the stimulus sequencer and the configuration loader.
- Per-requester handshake is req/gnt/done; arbitration is round-robin by default.
- Sequences each transaction so the bus protocol rules always hold:
  - no enable during reset;
  - addr held one cycle after enable;
  - wr_data held two cycles after a write;
  - read data captured after a fixed latency.

---
 rtl/mem_bus_arbiter_if.sv | 53 +++++
 rtl/mem_bus_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
// Purpose : groups the requester handshake, the response path and the shared
//           ALU/memory bus of mem_bus_arbiter into one bundle.
// Params  : NUM_REQ - number of requesters (2..4).
// Signals :
//   req/req_rd_wr/req_addr/req_wr_data - per-requester command, packed by index
//   gnt/done                           - one-hot pulses back to the requesters
//   rsp_rd_data/rsp_res_out            - captured read response
//   enable/rd_wr/addr/wr_data          - bus command driven by the arbiter
//   rd_data/res_out                    - bus return data
//   state_dbg                          - arbiter FSM state, for observation
// Modports:
//   master - the arbiter's view (drives the bus, gnt, done, rsp_*)
//   slave  - the environment's view (requesters plus the bus target)
//
// Handshake: a requester raises req[i] with its command fields stable and
// keeps them until done[i]. gnt[i] pulses for one cycle when the command goes
// onto the bus; done[i] pulses for one cycle when it has completed, and for a
// read rsp_* is valid in that same cycle. Dropping req after gnt does not
// cancel the transaction.
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_rd_wr;
    logic [2*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_wr_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic [7:0]           rsp_rd_data;
    logic [15:0]          rsp_res_out;
    logic                 enable;
    logic                 rd_wr;
    logic [1:0]           addr;
    logic [7:0]           wr_data;
    logic [7:0]           rd_data;
    logic [15:0]          res_out;
    logic [2:0]           state_dbg;

    modport master (
        input  req, req_rd_wr, req_addr, req_wr_data, rd_data, res_out,
        output gnt, done, rsp_rd_data, rsp_res_out,
               enable, rd_wr, addr, wr_data, state_dbg
    );

    modport slave (
        output req, req_rd_wr, req_addr, req_wr_data, rd_data, res_out,
        input  gnt, done, rsp_rd_data, rsp_res_out,
               enable, rd_wr, addr, wr_data, state_dbg
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Purpose : shares the single ALU/memory bus among NUM_REQ requesters and
//           sequences every transaction so that enable is a single-cycle
//           pulse, addr is held a cycle after enable, wr_data is held two
//           cycles after a write, and read data is captured a fixed
//           RD_LATENCY edges after the enable edge.
// Params  : NUM_REQ    - requesters (2..4)
//           RD_LATENCY - edges from the enable-sampling edge to the capture
//                        edge of rd_data/res_out (1..7)
// Ports   : clk - bus clock
//           rst - synchronous active-high reset; aborts any transaction
//           bus - mem_bus_arbiter_if.master (handshake, response, bus)
// Build option:
//   MEM_ARB_STRICT_PRIO_EN defined   -> fixed priority, lowest index wins
//   MEM_ARB_STRICT_PRIO_EN undefined -> round-robin from a rotating pointer
//   Timing is identical in both builds.
// FSM     : IDLE -> ISSUE -> HOLD -> (WAIT)* -> DONE -> IDLE
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int RD_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.master  bus
);
    localparam int IW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        HOLD  = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      sel_idx;
    logic               sel_valid;
    logic [NUM_REQ-1:0] win_onehot;
    logic [NUM_REQ-1:0] last_done;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [NUM_REQ-1:0] done_vec;
    logic               enable_c;
    logic               capture;
    logic [2:0]         lat_cnt;
    logic               bus_rd_wr;
    logic [1:0]         bus_addr;
    logic [7:0]         bus_wr_data;
    logic [7:0]         rsp_rd;
    logic [15:0]        rsp_res;

    // The requester that completed in the previous cycle is masked so another
    // waiting requester gets a turn. When nobody else is asking the mask is
    // dropped, so a lone requester streams back-to-back with one IDLE cycle.
    always_comb begin
        elig = bus.req & ~last_done;
        cand = (elig != '0) ? elig : bus.req;
    end

`ifdef MEM_ARB_STRICT_PRIO_EN
    // Fixed priority: scan downwards so the lowest set index is kept last.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_valid = 1'b1;
                sel_idx   = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] rr_ptr;

    // Round-robin: offsets scanned downwards so the smallest offset from
    // rr_ptr (modulo NUM_REQ) is the one that sticks.
    always_comb begin
        int idx;
        idx       = 0;
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (cand[idx]) begin
                sel_valid = 1'b1;
                sel_idx   = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (state == ISSUE) begin
            rr_ptr <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
        end
    end
`endif

    always_comb begin
        win_onehot = NUM_REQ'(1) << win_idx;
    end

    // Next state and per-state outputs. Everything visible is forced low
    // while rst is high so no enable/gnt/done can leak out during reset.
    always_comb begin
        state_nxt = state;
        gnt_vec   = '0;
        done_vec  = '0;
        enable_c  = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                enable_c  = 1'b1;
                gnt_vec   = win_onehot;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (!bus_rd_wr) begin
                    state_nxt = DONE;
                end else if (RD_LATENCY == 1) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // End of HOLD is edge 1 after the enable edge; WAIT cycle n
                // (lat_cnt = n) ends on edge n+2.
                if (lat_cnt == 3'(RD_LATENCY - 2)) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_vec  = win_onehot;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (rst) begin
            gnt_vec  = '0;
            done_vec = '0;
            enable_c = 1'b0;
            capture  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            win_idx     <= '0;
            last_done   <= '0;
            lat_cnt     <= '0;
            bus_rd_wr   <= 1'b0;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            rsp_rd      <= '0;
            rsp_res     <= '0;
        end else begin
            state     <= state_nxt;
            last_done <= done_vec;
            // Bus fields change only here, so they stay put from ISSUE
            // through DONE and keep their last values while IDLE.
            if (state == IDLE && sel_valid) begin
                win_idx     <= sel_idx;
                bus_rd_wr   <= bus.req_rd_wr[sel_idx];
                bus_addr    <= bus.req_addr[2*int'(sel_idx) +: 2];
                bus_wr_data <= bus.req_wr_data[8*int'(sel_idx) +: 8];
            end
            if (state == HOLD) begin
                lat_cnt <= '0;
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt + 3'd1;
            end
            if (capture) begin
                rsp_rd  <= bus.rd_data;
                rsp_res <= bus.res_out;
            end
        end
    end

    assign bus.gnt         = gnt_vec;
    assign bus.done        = done_vec;
    assign bus.enable      = enable_c;
    assign bus.rd_wr       = bus_rd_wr;
    assign bus.addr        = bus_addr;
    assign bus.wr_data     = bus_wr_data;
    assign bus.rsp_rd_data = rsp_rd;
    assign bus.rsp_res_out = rsp_res;
    assign bus.state_dbg   = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed bench for mem_bus_arbiter (NUM_REQ=2, RD_LATENCY=2). Inputs change
// 1 ns after the rising edge, outputs are observed on the falling edge. A
// background monitor checks the bus hold rules on every cycle.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
    localparam int NUM_REQ    = 2;
    localparam int RD_LATENCY = 2;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    mem_bus_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Bus hold monitor: enable never with rst, addr held the cycle after
    // enable, wr_data held for two cycles after a write enable.
    logic       p_en, pp_en, p_rw, pp_rw;
    logic [1:0] p_addr;
    logic [7:0] p_wd, pp_wd;
    initial begin
        p_en = 0; pp_en = 0; p_rw = 0; pp_rw = 0; p_addr = 0; p_wd = 0; pp_wd = 0;
    end
    always @(negedge clk) begin
        if (rst) check("en_in_rst", 32'(bus.enable), 32'd0);
        if (p_en) check("addr_hold", 32'(bus.addr), 32'(p_addr));
        if (p_en && !p_rw) check("wd_hold1", 32'(bus.wr_data), 32'(p_wd));
        if (pp_en && !pp_rw) check("wd_hold2", 32'(bus.wr_data), 32'(pp_wd));
        pp_en = p_en; pp_rw = p_rw; pp_wd = p_wd;
        p_en = bus.enable; p_rw = bus.rd_wr; p_addr = bus.addr; p_wd = bus.wr_data;
        if (rst) begin
            p_en = 0; pp_en = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int who, input logic rd, input logic [1:0] a, input logic [7:0] d);
        bus.req_rd_wr[who]            = rd;
        bus.req_addr[2*who +: 2]      = a;
        bus.req_wr_data[8*who +: 8]   = d;
        bus.req[who]                  = 1'b1;
    endtask

    // Starts in the cycle where the request is already presented; returns at
    // the falling edge of the ISSUE cycle. exp_wait is the number of cycles
    // with gnt low before it. No done may appear while waiting.
    task automatic wait_gnt(input string tag, input int exp_wait);
        int waited;
        waited = 0;
        @(negedge clk);
        while (bus.gnt == '0 && waited < 20) begin
            check({tag, "_no_done"}, 32'(bus.done), 32'd0);
            @(negedge clk);
            waited++;
        end
        check({tag, "_issue_lat"}, 32'(waited), 32'(exp_wait));
    endtask

    // Called at the falling edge of the ISSUE cycle T. Checks every cycle
    // through DONE (T+2 for writes, T+1+RD_LATENCY for reads). rd_data is only
    // correct in the cycle whose closing edge is the capture edge.
    task automatic expect_txn(input string tag, input int who, input logic rd,
                              input logic [1:0] a, input logic [7:0] d,
                              input logic [7:0] rdv, input logic [15:0] resv,
                              input bit keep);
        int done_at;
        done_at = rd ? 1 + RD_LATENCY : 2;
        check({tag, "_gnt"},    32'(bus.gnt),    32'(1 << who));
        check({tag, "_en"},     32'(bus.enable), 32'd1);
        check({tag, "_addr"},   32'(bus.addr),   32'(a));
        check({tag, "_rd_wr"},  32'(bus.rd_wr),  32'(rd));
        check({tag, "_done0"},  32'(bus.done),   32'd0);
        if (!rd) check({tag, "_wd"}, 32'(bus.wr_data), 32'(d));
        for (int k = 1; k <= done_at; k++) begin
            step();
            if (rd) begin
                bus.rd_data = (k == RD_LATENCY) ? rdv : ~rdv;
                bus.res_out = (k == RD_LATENCY) ? resv : ~resv;
            end
            @(negedge clk);
            check({tag, "_en_low"}, 32'(bus.enable), 32'd0);
            check({tag, "_gnt_low"}, 32'(bus.gnt), 32'd0);
            check({tag, "_addr_h"}, 32'(bus.addr), 32'(a));
            if (!rd) check({tag, "_wd_h"}, 32'(bus.wr_data), 32'(d));
            if (k < done_at) begin
                check({tag, "_done_early"}, 32'(bus.done), 32'd0);
            end else begin
                check({tag, "_done"}, 32'(bus.done), 32'(1 << who));
                if (rd) begin
                    check({tag, "_rsp_rd"},  32'(bus.rsp_rd_data), 32'(rdv));
                    check({tag, "_rsp_res"}, 32'(bus.rsp_res_out), 32'(resv));
                end
            end
        end
        if (!keep) bus.req[who] = 1'b0;
    endtask

`ifdef MEM_ARB_STRICT_PRIO_EN
    localparam int FRESH_FIRST = 0;
`else
    localparam int FRESH_FIRST = 1;
`endif

    // ---------------- stimulus ----------------
    initial begin
        n_checks        = 0;
        n_errors        = 0;
        rst             = 1'b1;
        bus.req         = '0;
        bus.req_rd_wr   = '0;
        bus.req_addr    = '0;
        bus.req_wr_data = '0;
        bus.rd_data     = 8'hEE;
        bus.res_out     = 16'hDEAD;

        // Reset held with both requesting: nothing may move.
        set_req(0, 1'b0, 2'd2, 8'hA5);
        set_req(1, 1'b0, 2'd1, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_outs", 32'({bus.enable, bus.gnt, bus.done}), 32'd0);
            check("rst_rsp",  32'({bus.rsp_rd_data, bus.rsp_res_out}), 32'd0);
            check("rst_bus",  32'({bus.addr, bus.wr_data, bus.rd_wr}), 32'd0);
            step();
        end
        rst = 1'b0;

        // First issue in the second cycle with rst low; requester 0 first.
        wait_gnt("wr0", 1);
        expect_txn("wr0", 0, 1'b0, 2'd2, 8'hA5, 8'h00, 16'h0000, 1'b0);
        wait_gnt("wr1", 1);
        expect_txn("wr1", 1, 1'b0, 2'd1, 8'h5A, 8'h00, 16'h0000, 1'b0);

        // Single read from requester 1.
        step();
        set_req(1, 1'b1, 2'd3, 8'h00);
        wait_gnt("rd1", 1);
        expect_txn("rd1", 1, 1'b1, 2'd3, 8'h00, 8'h3C, 16'h1234, 1'b0);

        // Contention: both held for four transactions -> 0,1,0,1.
        step();
        set_req(0, 1'b0, 2'd0, 8'h10);
        set_req(1, 1'b0, 2'd1, 8'h20);
        for (int t = 0; t < 4; t++) begin
            wait_gnt("cont", 1);
            expect_txn("cont", t % 2, 1'b0, 2'(t % 2), (t % 2) ? 8'h20 : 8'h10,
                       8'h00, 16'h0000, (t < 3) ? 1'b1 : 1'b0);
        end
        bus.req = '0;
        check("rsp_keep_rd",  32'(bus.rsp_rd_data), 32'h3C);
        check("rsp_keep_res", 32'(bus.rsp_res_out), 32'h1234);

        // Pointer moved to 1 by a grant to 0; fresh simultaneous requests then
        // go to 1 under round-robin and to 0 under fixed priority.
        step();
        set_req(0, 1'b0, 2'd3, 8'h99);
        wait_gnt("ptr_set", 1);
        expect_txn("ptr_set", 0, 1'b0, 2'd3, 8'h99, 8'h00, 16'h0000, 1'b0);
        step();
        step();
        set_req(0, 1'b0, 2'd0, 8'h01);
        set_req(1, 1'b0, 2'd1, 8'h02);
        wait_gnt("fresh_a", 1);
        expect_txn("fresh_a", FRESH_FIRST, 1'b0, 2'(FRESH_FIRST),
                   FRESH_FIRST ? 8'h02 : 8'h01, 8'h00, 16'h0000, 1'b0);
        wait_gnt("fresh_b", 1);
        expect_txn("fresh_b", 1 - FRESH_FIRST, 1'b0, 2'(1 - FRESH_FIRST),
                   FRESH_FIRST ? 8'h01 : 8'h02, 8'h00, 16'h0000, 1'b0);

        // Reset in the WAIT cycle of a read: no done, pointer back to 0.
        step();
        set_req(0, 1'b1, 2'd2, 8'h00);
        wait_gnt("abort", 1);
        check("abort_gnt", 32'(bus.gnt), 32'd1);
        step();
        @(negedge clk);
        check("abort_state_hold", 32'(bus.state_dbg), 32'd2);
        step();
        check("abort_state_wait", 32'(bus.state_dbg), 32'd3);
        rst     = 1'b1;
        bus.req = '0;
        @(negedge clk);
        check("abort_en",   32'(bus.enable), 32'd0);
        check("abort_done", 32'(bus.done),   32'd0);
        step();
        rst = 1'b0;
        check("abort_idle", 32'(bus.state_dbg), 32'd0);
        set_req(0, 1'b1, 2'd2, 8'h00);
        set_req(1, 1'b1, 2'd1, 8'h00);
        wait_gnt("post_rst0", 1);
        check("post_rst_rsp", 32'(bus.rsp_rd_data), 32'd0);
        expect_txn("post_rst0", 0, 1'b1, 2'd2, 8'h00, 8'h77, 16'hBEEF, 1'b0);
        wait_gnt("post_rst1", 1);
        expect_txn("post_rst1", 1, 1'b1, 2'd1, 8'h00, 8'h5A, 16'h0F0F, 1'b0);

        // Back-to-back writes by requester 0: one IDLE between, enable every 4.
        step();
        set_req(0, 1'b0, 2'd0, 8'h11);
        for (int i = 0; i < 4; i++) begin
            wait_gnt("b2b", 1);
            expect_txn("b2b", 0, 1'b0, 2'(i), 8'(8'h11 * (i + 1)), 8'h00, 16'h0000,
                       (i < 3) ? 1'b1 : 1'b0);
            if (i < 3) set_req(0, 1'b0, 2'(i + 1), 8'(8'h11 * (i + 2)));
        end
        check("b2b_rsp_rd",  32'(bus.rsp_rd_data), 32'h5A);
        check("b2b_rsp_res", 32'(bus.rsp_res_out), 32'h0F0F);

        step();
        step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
